// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz scoring datapath.
//   state_t      : round sequencer states
//   WHO_*        : responder codes carried on the 'who' bus
//   TIME_W       : width of the countdown bus shared with score_control/score_file
//   score_pl_t   : payload handed to score_control on each scoring strobe
package quiz_pkg;

    localparam int unsigned TIME_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ASK   = 3'd1,
        ST_LOCK  = 3'd2,
        ST_SCORE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_A    = 2'b01;
    localparam logic [1:0] WHO_B    = 2'b10;
    localparam logic [1:0] WHO_BOTH = 2'b11;

    typedef struct packed {
        logic [TIME_W-1:0] count;
        logic [1:0]        who;
        logic              right;
    } score_pl_t;

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// Control/scoring bus of quiz_round_ctrl.
//   master : drives start/tick/buzzers/verdict, observes scoring outputs
//   slave  : the round controller
interface quiz_round_ctrl_if #(
    parameter int unsigned ROUND_W = 4
);
    import quiz_pkg::*;

    logic                start;
    logic                tick;
    logic                buzz_a;
    logic                buzz_b;
    logic                judge_valid;
    logic                judge_right;
    logic [TIME_W-1:0]   count;
    logic [1:0]          who;
    logic                right;
    logic                score_valid;
    logic [ROUND_W-1:0]  round;
    logic                busy;
    logic                game_over;

    modport master (
        output start, tick, buzz_a, buzz_b, judge_valid, judge_right,
        input  count, who, right, score_valid, round, busy, game_over
    );

    modport slave (
        input  start, tick, buzz_a, buzz_b, judge_valid, judge_right,
        output count, who, right, score_valid, round, busy, game_over
    );

endinterface

// File: rtl/buzz_edge_detect.sv
// Rising-edge detector for one buzzer level.
//   clk, rst : clock, async active-high reset
//   buzz     : buzzer level, synchronous to clk
//   rise_c   : combinational, high in the cycle buzz goes 0->1
module buzz_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic buzz,
    output logic rise_c
);

    logic hist_q, hist_d;

    // History tracks the level every cycle, so a buzzer held high never re-triggers.
    always_comb hist_d = buzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= 1'b0;
        else     hist_q <= hist_d;
    end

    assign rise_c = buzz & ~hist_q;

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer: runs the countdown, arbitrates two buzzers, collects
// the judge's verdict, emits a one-cycle scoring strobe and counts rounds.
//   clk, rst : clock, async active-high reset
//   bus      : quiz_round_ctrl_if.slave (inputs start/tick/buzz_a/buzz_b/
//              judge_valid/judge_right; registered outputs count/who/right/
//              score_valid/round/busy/game_over)
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int unsigned TIME_LIMIT = 200,
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned ROUND_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    quiz_round_ctrl_if.slave bus
);

    state_t             state_q, state_d;
    score_pl_t          pl_q, pl_d;
    logic               score_valid_q, score_valid_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               busy_q, busy_d;
    logic               game_over_q, game_over_d;
    logic               rise_a_c, rise_b_c;

    buzz_edge_detect u_edge_a (.clk(clk), .rst(rst), .buzz(bus.buzz_a), .rise_c(rise_a_c));
    buzz_edge_detect u_edge_b (.clk(clk), .rst(rst), .buzz(bus.buzz_b), .rise_c(rise_b_c));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a buzz takes priority over the final tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_ASK;
            ST_ASK: begin
                if (rise_a_c | rise_b_c)                           state_d = ST_LOCK;
                else if (bus.tick && pl_q.count == TIME_W'(1))     state_d = ST_SCORE;
            end
            ST_LOCK:  if (bus.judge_valid) state_d = ST_SCORE;
            ST_SCORE: state_d = (round_q == ROUND_W'(NUM_ROUNDS)) ? ST_DONE : ST_IDLE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; status flags follow the next state so they are registered.
    always_comb begin
        pl_d          = pl_q;
        round_d       = round_q;
        score_valid_d = (state_d == ST_SCORE);
        busy_d        = (state_d == ST_ASK) || (state_d == ST_LOCK) || (state_d == ST_SCORE);
        game_over_d   = (state_d == ST_DONE);
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pl_d.count = TIME_W'(TIME_LIMIT);
                    pl_d.who   = WHO_NONE;
                    pl_d.right = 1'b0;
                    round_d    = round_q + ROUND_W'(1);
                end
            end
            ST_ASK: begin
                if (rise_a_c | rise_b_c) begin
                    pl_d.who = {rise_b_c, rise_a_c};
                end else if (bus.tick) begin
                    if (pl_q.count == TIME_W'(1)) begin
                        pl_d.count = '0;
                        pl_d.who   = WHO_NONE;
                        pl_d.right = 1'b0;
                    end else begin
                        pl_d.count = pl_q.count - TIME_W'(1);
                    end
                end
            end
            ST_LOCK: if (bus.judge_valid) pl_d.right = bus.judge_right;
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pl_q          <= '0;
            score_valid_q <= 1'b0;
            round_q       <= '0;
            busy_q        <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            pl_q          <= pl_d;
            score_valid_q <= score_valid_d;
            round_q       <= round_d;
            busy_q        <= busy_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.count       = pl_q.count;
    assign bus.who         = pl_q.who;
    assign bus.right       = pl_q.right;
    assign bus.score_valid = score_valid_q;
    assign bus.round       = round_q;
    assign bus.busy        = busy_q;
    assign bus.game_over   = game_over_q;

endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
- Sequences one quiz round at a time for the two-player scoring datapath.
- Loads and counts down the question timer, arbitrates the two buzzers and collects the judge's verdict.
- Issues a one-cycle scoring strobe carrying count/who/right to score_control, whose outputs feed score_file.
- Counts rounds and raises game_over after the last round.

Parameters:
TIME_LIMIT, 200, countdown start value loaded into count at round start (1..255).
NUM_ROUNDS, 10, rounds per game (1..15).
ROUND_W, 4, width of round counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
start  in  1  request to begin the next round; honoured only in IDLE.
tick  in  1  one-cycle time-base enable; decrements count in ASK only.
buzz_a  in  1  player A buzzer, level, synchronous to clk.
buzz_b  in  1  player B buzzer, level, synchronous to clk.
judge_valid  in  1  one-cycle verdict strobe; honoured only in LOCK.
judge_right  in  1  verdict: 1 = correct answer, qualified by judge_valid.
count  out  8  remaining time; to score_control.count.
who  out  2  responder: 00 none, 01 A, 10 B, 11 both (tie).
right  out  1  latched verdict; to score_control.right.
score_valid  out  1  one-cycle strobe; count/who/right valid for scoring.
round  out  ROUND_W  current round number, 1-based; 0 before the first start.
busy  out  1  high in ASK, LOCK and SCORE.
game_over  out  1  high in DONE.

Behaviour:
- Reset (async, rst=1): state IDLE, count=0, who=00, right=0, score_valid=0, round=0, busy=0, game_over=0, buzzer history regs=0.
- States: IDLE, ASK, LOCK, SCORE, DONE. Binary encoding. All outputs are registered.
- IDLE:
  - start=1 -> ASK next cycle.
  - On that transition: count<=TIME_LIMIT, round<=round+1, who<=00, right<=0, busy=1.
- ASK:
  - Rising-edge detect per buzzer: rise_x = buzz_x & ~buzz_x_d. buzz_x_d is updated every cycle in every state.
  - A buzzer already high on ASK entry does not count; it must go low and then high again.
  - rise_a & rise_b -> who<=11, LOCK.
  - rise_a only -> who<=01, LOCK. rise_b only -> who<=10, LOCK.
  - Latency: edge seen in cycle N -> who/state updated at edge N+1.
  - tick with count>1: count<=count-1.
  - tick with count==1 and no rise: count<=0, who<=00, right<=0, then SCORE (timeout).
  - Buzz and final tick in the same cycle: buzz wins, count stays 1.
  - tick with count==0 cannot occur; count never wraps.
- LOCK:
  - count frozen; all buzzer edges ignored; tick ignored.
  - judge_valid=1 -> right<=judge_right, then SCORE.
  - No timeout in LOCK; the block waits indefinitely for the verdict.
- SCORE:
  - Exactly one cycle. score_valid=1 with count/who/right stable.
  - Next state: DONE if round==NUM_ROUNDS, else IDLE. busy drops on exit.
  - who/right/count hold their values until the next round start.
- DONE:
  - game_over=1, busy=0. start ignored.
  - Only rst leaves DONE.
- start outside IDLE is ignored. judge_valid outside LOCK is ignored.
- rst asserted mid-round aborts the round immediately; no score_valid is emitted.
- round width: NUM_ROUNDS must be less than 2**ROUND_W. The counter never wraps because DONE is terminal.

Decomposition:
- Shared package quiz_pkg:
  - state enum (IDLE/ASK/LOCK/SCORE/DONE).
  - WHO_NONE=2'b00, WHO_A=2'b01, WHO_B=2'b10, WHO_BOTH=2'b11.
  - TIME_W=8, shared with score_control and score_file.
- One sub-module, buzz_edge_detect: a 1-bit registered-history rising-edge detector, instantiated once per player, reset to 0.

Test Plan:
- rst, start, 3 ticks, buzz_a rises -> count=197, who=01 one cycle later. judge_valid with judge_right=1 -> score_valid pulse with count=197, who=01, right=1; round=1; then IDLE.
- buzz_a and buzz_b rise in the same cycle -> who=11. Judge with right=0 -> score_valid with who=11, right=0.
- TIME_LIMIT=3, no buzz, 3 ticks -> count=0, who=00, right=0, single score_valid pulse.
- buzz_b held high before start -> no lock in ASK. Drop buzz_b, re-raise it -> who=10. On the last tick with count==1, a simultaneous buzz_a rise -> who=01, count=1.
- NUM_ROUNDS=2, play two rounds -> game_over=1 after the second score_valid, busy=0; a further start leaves round=2 and state DONE.
- rst pulse while in LOCK -> all outputs return to their reset values immediately; no score_valid; a following start gives round=1.
